// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the CPU sequencer: instruction word, state encoding, HALT opcode.
package opcodes;

    localparam int unsigned INSTR_W = 32;

    typedef logic [INSTR_W-1:0] instruction_t;

    // Encodings are fixed; 3'd7 is unused and treated as a fault condition.
    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_BREAK     = 3'd4,
        ST_MEMORY    = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    // Instruction word that parks the sequencer in BREAK after it retires.
    localparam instruction_t HALT = 32'h0010_0073;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Pipeline handshake bundle between the sequencer and its memories / execute unit.
//   master: sequencer side (drives requests and strobes, samples acks and decode info)
//   slave : datapath side (drives acks, instruction word and decode info)
interface cpu_sequencer_if;
    import opcodes::*;

    instruction_t instr;
    logic         is_mem;
    logic         imem_req;
    logic         imem_ack;
    logic         dmem_req;
    logic         dmem_ack;
    logic         ex_start;
    logic         ex_done;
    logic         wb_en;

    modport master (
        output imem_req, dmem_req, ex_start, wb_en,
        input  instr, is_mem, imem_ack, dmem_ack, ex_done
    );

    modport slave (
        input  imem_req, dmem_req, ex_start, wb_en,
        output instr, is_mem, imem_ack, dmem_ack, ex_done
    );

endinterface

// File: rtl/cpu_sequencer_ack_timer.sv
// Ack wait counter: counts ticks since the last clear and flags when the limit is reached.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart the count from zero (takes priority over tick)
//   tick       : one cycle spent waiting without an ack
//   expired    : registered, high while the count equals ACK_TIMEOUT
module ack_timer #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned TW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] LIMIT = TW'(ACK_TIMEOUT);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          expired_q, expired_d;

    // Saturating count; expired is precomputed from the next count so it is a flop output.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + TW'(1);
        end
        expired_d = (cnt_d == LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= (LIMIT == '0);
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// single-step / HALT break handling and an ack-timeout fault trap.
//   clk, rst_n   : clock, async active-low reset
//   bus          : handshake bundle (imem/dmem req-ack, ex_start/ex_done, wb_en, instr, is_mem)
//   step_en      : stop in BREAK after each retired instruction
//   resume       : leave BREAK
//   state        : current state encoding
//   halted/fault : in BREAK / in FAULT (fault is held until reset)
//   cycle_cnt    : cycles spent outside BREAK and FAULT, wraps
//   retired_cnt  : retired instructions, wraps
module cpu_sequencer
    import opcodes::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_sequencer_if.master      bus,
    input  logic                 step_en,
    input  logic                 resume,
    output logic [2:0]           state,
    output logic                 halted,
    output logic                 fault,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     retired_cnt
);

    state_t             state_q, state_d;
    logic               imem_req_q, imem_req_d;
    logic               dmem_req_q, dmem_req_d;
    logic               ex_start_q, ex_start_d;
    logic               wb_en_q, wb_en_d;
    logic               halted_q, halted_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]   retired_cnt_q, retired_cnt_d;
    logic               timer_clear;
    logic               timer_tick;
    logic               timer_expired;

    ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .tick    (timer_tick),
        .expired (timer_expired)
    );

    // Next state, timer control, and next values of the registered outputs/counters.
    always_comb begin
        state_d       = state_q;
        timer_tick    = 1'b0;
        timer_clear   = 1'b0;
        imem_req_d    = 1'b0;
        dmem_req_d    = 1'b0;
        ex_start_d    = 1'b0;
        wb_en_d       = 1'b0;
        halted_d      = 1'b0;
        fault_d       = 1'b0;
        cycle_cnt_d   = cycle_cnt_q;
        retired_cnt_d = retired_cnt_q;

        case (state_q)
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    state_d = ST_DECODE;
                end else begin
                    timer_tick = 1'b1;
                    if (timer_expired) state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (bus.ex_done) state_d = bus.is_mem ? ST_MEMORY : ST_WRITEBACK;
            end
            ST_MEMORY: begin
                if (bus.dmem_ack) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    timer_tick = 1'b1;
                    if (timer_expired) state_d = ST_FAULT;
                end
            end
            ST_WRITEBACK: begin
                if ((bus.instr == HALT) || step_en) state_d = ST_BREAK;
                else                                state_d = ST_FETCH;
            end
            ST_BREAK: begin
                if (resume) state_d = ST_FETCH;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase

        // Any state change restarts the wait count, so FETCH/MEMORY always enter at zero.
        timer_clear = (state_d != state_q);

        // Outputs are flopped from the next state, i.e. a pure decode of the state register.
        imem_req_d = (state_d == ST_FETCH);
        dmem_req_d = (state_d == ST_MEMORY);
        ex_start_d = (state_d == ST_EXECUTE) && (state_q != ST_EXECUTE);
        wb_en_d    = (state_d == ST_WRITEBACK);
        halted_d   = (state_d == ST_BREAK);
        fault_d    = (state_d == ST_FAULT);

        if ((state_q != ST_BREAK) && (state_q != ST_FAULT)) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (state_q == ST_WRITEBACK) begin
            retired_cnt_d = retired_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FETCH;
            imem_req_q    <= 1'b1;
            dmem_req_q    <= 1'b0;
            ex_start_q    <= 1'b0;
            wb_en_q       <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            dmem_req_q    <= dmem_req_d;
            ex_start_q    <= ex_start_d;
            wb_en_q       <= wb_en_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign bus.imem_req = imem_req_q;
    assign bus.dmem_req = dmem_req_q;
    assign bus.ex_start = ex_start_q;
    assign bus.wb_en    = wb_en_q;
    assign state        = state_q;
    assign halted       = halted_q;
    assign fault        = fault_q;
    assign cycle_cnt    = cycle_cnt_q;
    assign retired_cnt  = retired_cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer (CNT_W=4 so counter wrap is reachable quickly).
module tb_cpu_sequencer;
    import opcodes::*;

    localparam instruction_t ADD = 32'h0000_0033;

    logic       clk;
    logic       rst_n;
    logic       step_en;
    logic       resume;
    logic [2:0] state;
    logic       halted;
    logic       fault;
    logic [3:0] cycle_cnt;
    logic [3:0] retired_cnt;

    int checks   = 0;
    int failures = 0;
    int n_ex_start;
    int n_break;

    cpu_sequencer_if bus ();

    cpu_sequencer #(
        .CNT_W       (4),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .step_en     (step_en),
        .resume      (resume),
        .state       (state),
        .halted      (halted),
        .fault       (fault),
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.instr    = ADD;
        bus.is_mem   = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.ex_done  = 1'b0;
        step_en      = 1'b0;
        resume       = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One ALU instruction with immediate acks: FETCH, DECODE, EXECUTE, WRITEBACK, FETCH.
    task automatic run_add();
        bus.instr    = ADD;
        bus.is_mem   = 1'b0;
        bus.imem_ack = 1'b1;
        bus.ex_done  = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #2;
        tick();
        tick();
        chk("rst_state",    32'(state), 32'd0);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd1);
        chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_ex_start", 32'(bus.ex_start), 32'd0);
        chk("rst_wb_en",    32'(bus.wb_en), 32'd0);
        chk("rst_halted",   32'(halted), 32'd0);
        chk("rst_fault",    32'(fault), 32'd0);
        chk("rst_cycle",    32'(cycle_cnt), 32'd0);
        chk("rst_retired",  32'(retired_cnt), 32'd0);
        rst_n = 1'b1;

        // ADD: 0,1,2,3,0
        bus.instr    = ADD;
        bus.imem_ack = 1'b1;
        bus.ex_done  = 1'b1;
        chk("add_imem_req_first", 32'(bus.imem_req), 32'd1);
        tick();
        chk("add_s1", 32'(state), 32'd1);
        bus.imem_ack = 1'b0;
        tick();
        chk("add_s2", 32'(state), 32'd2);
        chk("add_ex_start", 32'(bus.ex_start), 32'd1);
        tick();
        chk("add_s3", 32'(state), 32'd3);
        chk("add_wb_en", 32'(bus.wb_en), 32'd1);
        tick();
        chk("add_s4", 32'(state), 32'd0);
        chk("add_wb_off", 32'(bus.wb_en), 32'd0);
        chk("add_retired", 32'(retired_cnt), 32'd1);
        chk("add_cycle", 32'(cycle_cnt), 32'd4);

        // LOAD: 0,1,2,2,5,5,5,3 with a stray resume that must be ignored
        n_ex_start   = 0;
        bus.is_mem   = 1'b1;
        bus.ex_done  = 1'b0;
        bus.imem_ack = 1'b1;
        tick();
        chk("ld_s1", 32'(state), 32'd1);
        bus.imem_ack = 1'b0;
        resume       = 1'b1;
        tick();
        n_ex_start = n_ex_start + int'(bus.ex_start);
        chk("ld_s2", 32'(state), 32'd2);
        tick();
        n_ex_start = n_ex_start + int'(bus.ex_start);
        chk("ld_s3", 32'(state), 32'd2);
        bus.ex_done = 1'b1;
        tick();
        n_ex_start = n_ex_start + int'(bus.ex_start);
        chk("ld_s4", 32'(state), 32'd5);
        chk("ld_dmem_req", 32'(bus.dmem_req), 32'd1);
        bus.ex_done = 1'b0;
        tick();
        chk("ld_s5", 32'(state), 32'd5);
        tick();
        chk("ld_s6", 32'(state), 32'd5);
        bus.dmem_ack = 1'b1;
        tick();
        n_ex_start = n_ex_start + int'(bus.ex_start);
        chk("ld_s7", 32'(state), 32'd3);
        chk("ld_dmem_off", 32'(bus.dmem_req), 32'd0);
        bus.dmem_ack = 1'b0;
        resume       = 1'b0;
        chk("ld_ex_start_once", 32'(n_ex_start), 32'd1);
        tick();
        chk("ld_back_fetch", 32'(state), 32'd0);
        chk("ld_retired", 32'(retired_cnt), 32'd2);

        // HALT: 4 counted cycles bring cycle_cnt to 16, i.e. 0 in 4 bits
        bus.instr    = HALT;
        bus.is_mem   = 1'b0;
        bus.imem_ack = 1'b1;
        bus.ex_done  = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        tick();
        tick();
        chk("halt_state", 32'(state), 32'd4);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_imem_req", 32'(bus.imem_req), 32'd0);
        chk("halt_retired", 32'(retired_cnt), 32'd3);
        repeat (10) tick();
        chk("halt_still", 32'(state), 32'd4);
        chk("halt_cycle_frozen", 32'(cycle_cnt), 32'd0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("halt_resume_fetch", 32'(state), 32'd0);
        chk("halt_resume_halted", 32'(halted), 32'd0);
        chk("halt_resume_cycle", 32'(cycle_cnt), 32'd0);

        // Single-step over three instructions
        do_reset();
        step_en = 1'b1;
        n_break = 0;
        for (int i = 0; i < 3; i++) begin
            bus.instr    = ADD;
            bus.imem_ack = 1'b1;
            bus.ex_done  = 1'b1;
            tick();
            bus.imem_ack = 1'b0;
            tick();
            tick();
            tick();
            if (state == 3'd4) n_break = n_break + 1;
            resume = 1'b1;
            tick();
            resume = 1'b0;
            chk("step_resume_fetch", 32'(state), 32'd0);
        end
        step_en = 1'b0;
        chk("step_breaks", 32'(n_break), 32'd3);
        chk("step_retired", 32'(retired_cnt), 32'd3);

        // Retired counter wraps: 17 mod 16 = 1
        do_reset();
        repeat (17) run_add();
        chk("wrap_state", 32'(state), 32'd0);
        chk("wrap_retired", 32'(retired_cnt), 32'd1);

        // Reset in EXECUTE aborts immediately with no write strobe
        bus.imem_ack = 1'b1;
        bus.ex_done  = 1'b0;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        chk("abort_in_ex", 32'(state), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_wb_en", 32'(bus.wb_en), 32'd0);
        chk("abort_retired", 32'(retired_cnt), 32'd0);
        bus.ex_done = 1'b1;
        tick();
        chk("abort_wb_held", 32'(bus.wb_en), 32'd0);
        bus.ex_done = 1'b0;
        rst_n       = 1'b1;

        // imem_ack never comes: 16 FETCH cycles then FAULT
        repeat (15) tick();
        chk("to_last_fetch", 32'(state), 32'd0);
        tick();
        chk("to_fault_state", 32'(state), 32'd6);
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_imem_req", 32'(bus.imem_req), 32'd0);
        chk("to_cycle", 32'(cycle_cnt), 32'd0);
        bus.imem_ack = 1'b1;
        resume       = 1'b1;
        repeat (5) tick();
        chk("to_fault_sticky", 32'(state), 32'd6);
        chk("to_fault_held", 32'(fault), 32'd1);
        chk("to_cycle_frozen", 32'(cycle_cnt), 32'd0);
        do_reset();
        chk("to_reset_fault", 32'(fault), 32'd0);
        chk("to_reset_state", 32'(state), 32'd0);

        // An ack on the limit cycle wins over the timeout
        repeat (15) tick();
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        chk("limit_ack_state", 32'(state), 32'd1);
        chk("limit_ack_fault", 32'(fault), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter CNT_W, default 32: width of the cycle and retired-instruction counters.
REQ-002 Parameter ACK_TIMEOUT, default 15: maximum wait cycles for an imem/dmem ack before a fault.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 instr  input  instruction_t: current instruction word, compared against HALT.
REQ-006 is_mem  input  1: decoded instruction needs a data-memory access; sampled in EXECUTE.
REQ-007 imem_ack  input  1: instruction memory has completed the fetch.
REQ-008 dmem_ack  input  1: data memory has completed the access.
REQ-009 ex_done  input  1: execute unit has finished the current operation.
REQ-010 step_en  input  1: single-step mode; stop in BREAK after every retired instruction.
REQ-011 resume  input  1: leave BREAK.
REQ-012 state  output  3: current state encoding.
REQ-013 imem_req  output  1: instruction fetch request.
REQ-014 dmem_req  output  1: data access request.
REQ-015 ex_start  output  1: one-cycle pulse that starts the execute unit.
REQ-016 wb_en  output  1: register-file write strobe.
REQ-017 halted  output  1: sequencer is in BREAK.
REQ-018 fault  output  1: sequencer is in FAULT; sticky.
REQ-019 cycle_cnt  output  CNT_W: count of non-BREAK, non-FAULT cycles since reset.
REQ-020 retired_cnt  output  CNT_W: count of retired instructions.

Function
REQ-021 States and encodings SHALL be FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, BREAK=4, MEMORY=5, FAULT=6; encoding 7 SHALL go to FAULT.
REQ-022 FETCH: imem_req=1; imem_ack -> DECODE in the next cycle; otherwise stay.
REQ-023 DECODE: one cycle, then unconditionally -> EXECUTE.
REQ-024 EXECUTE:
- ex_start=1 only in the first EXECUTE cycle.
- Stay while ex_done=0.
- On ex_done, including in the first cycle: -> MEMORY if is_mem=1, else -> WRITEBACK.
REQ-025 MEMORY: dmem_req=1; dmem_ack -> WRITEBACK; otherwise stay.
REQ-026 WRITEBACK: wb_en=1 for exactly one cycle; retired_cnt increments by 1.
REQ-027 WRITEBACK next state, in priority order:
- instr==HALT -> BREAK;
- else step_en=1 -> BREAK;
- else -> FETCH.
REQ-028 BREAK: halted=1; resume=1 -> FETCH next cycle, including after HALT; otherwise stay.
REQ-029 Ack timeout:
- A wait counter clears on entry to FETCH or MEMORY.
- It increments each cycle without the matching ack.
- When it reaches ACK_TIMEOUT with no ack that cycle -> FAULT.
- An ack in the same cycle as the limit wins.
REQ-030 FAULT: fault=1; request and strobe outputs=0; exits only on reset.
REQ-031 Request and strobe outputs SHALL be Moore outputs decoded from state only, registered-state based and glitch-free.
REQ-032 cycle_cnt and retired_cnt SHALL wrap modulo 2^CNT_W; cycle_cnt holds in BREAK and FAULT.
REQ-033 resume and step_en outside BREAK/WRITEBACK SHALL be ignored.

Reset
REQ-034 rst_n low SHALL force, asynchronously:
- state=FETCH;
- all counters, including the wait counter, =0;
- halted=0, fault=0.
REQ-035 Reset asserted mid-operation in any state SHALL abort without a wb_en pulse.
REQ-036 After rst_n deasserts, imem_req SHALL be 1 on the first clock.

Structure
REQ-037 state_t enum, its encodings and the HALT opcode SHALL live in package opcodes; the module SHALL import it.
REQ-038 The wait counter SHALL be a sub-module ack_timer (inputs clear, tick; output expired), parametrised by ACK_TIMEOUT.

Verification
REQ-039 ADD with 1-cycle acks and ex_done, is_mem=0 -> states 0,1,2,3,0; wb_en in cycle 4; retired_cnt=1.
REQ-040 LOAD with is_mem=1, dmem_ack after 3 cycles, ex_done after 2 cycles -> state sequence 0,1,2,2,5,5,5,3; ex_start high once.
REQ-041 HALT instruction -> BREAK, halted=1, cycle_cnt frozen for 10 cycles; resume pulse -> FETCH the next cycle.
REQ-042 imem_ack never asserted, ACK_TIMEOUT=15 -> FAULT after 16 FETCH cycles with fault=1; FAULT held until rst_n=0.
REQ-043 step_en=1 over 3 instructions, resume after each -> 3 BREAK entries; retired_cnt=3.
REQ-044 CNT_W=4, 17 retired instructions -> retired_cnt wraps to 1; rst_n pulse in EXECUTE -> FETCH immediately, no wb_en.
